z80_cache_loader: RTL and testbench



---
 rtl/z80db_pkg.sv | 22 ++
 rtl/z80_cache_loader_if.sv | 41 ++++
 rtl/z80db_sync2.sv | 25 ++
 rtl/z80_cache_loader.sv | 119 +++++++++++
 tb/tb_z80_cache_loader.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z80db_pkg.sv
// z80db_pkg: shared types and constants for the Z80 debug board blocks.
// Loader FSM encoding, SRAM/length widths and active-low levels.
package z80db_pkg;

  localparam int SRAM_AW = 14;
  localparam int LEN_W   = 15;

  localparam logic ACT   = 1'b0;
  localparam logic INACT = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_REQ     = 3'd1;
  localparam state_t S_ADDR    = 3'd2;
  localparam state_t S_SETUP   = 3'd3;
  localparam state_t S_STROBE  = 3'd4;
  localparam state_t S_HOLD    = 3'd5;
  localparam state_t S_RELEASE = 3'd6;
  localparam state_t S_WREL    = 3'd7;

endpackage

// File: rtl/z80_cache_loader_if.sv
// z80_cache_loader_if: host stream, Z80 bus arbitration and SRAM pins.
// master = the loader, slave = host/board side.
interface z80_cache_loader_if;
  import z80db_pkg::*;

  logic               start;
  logic               abort;
  logic               bank;
  logic [SRAM_AW-1:0] base_addr;
  logic [LEN_W-1:0]   length;
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic               busrq;
  logic               busak;
  logic               bus_oe;
  logic [SRAM_AW-1:0] a_out;
  logic [7:0]         d_out;
  logic               ma14;
  logic               mce;
  logic               mwe;
  logic               moe;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    input  start, abort, bank, base_addr, length,
    input  s_data, s_valid, busak,
    output s_ready, busrq, bus_oe, a_out, d_out,
    output ma14, mce, mwe, moe, busy, done, err
  );

  modport slave (
    output start, abort, bank, base_addr, length,
    output s_data, s_valid, busak,
    input  s_ready, busrq, bus_oe, a_out, d_out,
    input  ma14, mce, mwe, moe, busy, done, err
  );

endinterface

// File: rtl/z80db_sync2.sv
// z80db_sync2: two-flop synchroniser for asynchronous Z80 inputs.
// Reset value is selectable so active-low lines reset inactive.
module z80db_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/z80_cache_loader.sv
// z80_cache_loader: takes the Z80 bus and fills the shadow-ROM cache SRAM
// from a host byte stream using timed CE/WE write cycles.
module z80_cache_loader
  import z80db_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int WE_CYC      = 2,
  parameter int HOLD_CYC    = 1,
  parameter int ACK_TIMEOUT = 1023
) (
  input logic                clk,
  input logic                reset,
  z80_cache_loader_if.master bus
);

  localparam int CW =
    $clog2(ACK_TIMEOUT + SETUP_CYC + WE_CYC + HOLD_CYC + 1);

  state_t           state;
  state_t           nstate;
  logic [CW-1:0]    cnt;
  logic [LEN_W-1:0] rem;
  logic             bank_q;
  logic             ack_n;
  logic             go;
  logic             last;

  z80db_sync2 #(.RST_VAL(INACT)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.busak),
    .q     (ack_n)
  );

  assign go   = (state == S_IDLE) && bus.start && (bus.length != '0);
  assign last = (rem == LEN_W'(1));

  // abort blocks the handshake so a refused byte stays with the host
  assign bus.s_ready = (state == S_ADDR) && !bus.abort;
  assign bus.moe     = INACT;

  // next-state decode; phase counters restart on every state change
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:    if (go) nstate = S_REQ;
      S_REQ: begin
        if (ack_n == ACT)              nstate = S_ADDR;
        else if (cnt == CW'(ACK_TIMEOUT)) nstate = S_IDLE;
      end
      S_ADDR: begin
        if (bus.abort)        nstate = S_RELEASE;
        else if (bus.s_valid) nstate = S_SETUP;
      end
      S_SETUP:   if (cnt == CW'(SETUP_CYC - 1)) nstate = S_STROBE;
      S_STROBE:  if (cnt == CW'(WE_CYC - 1))    nstate = S_HOLD;
      S_HOLD: begin
        if (cnt == CW'(HOLD_CYC - 1))
          nstate = last ? S_RELEASE : S_ADDR;
      end
      S_RELEASE: nstate = S_WREL;
      S_WREL:    if (ack_n == INACT) nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
  end

  // state, datapath and glitch-free registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rem        <= '0;
      bank_q     <= 1'b0;
      bus.a_out  <= '0;
      bus.d_out  <= '0;
      bus.ma14   <= 1'b0;
      bus.busrq  <= INACT;
      bus.bus_oe <= 1'b0;
      bus.mce    <= INACT;
      bus.mwe    <= INACT;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= (nstate != state) ? '0 : cnt + 1'b1;
      bus.busrq  <= (nstate == S_IDLE) || (nstate == S_WREL);
      bus.bus_oe <= nstate inside {S_ADDR, S_SETUP, S_STROBE, S_HOLD};
      bus.mce    <= !(nstate inside {S_SETUP, S_STROBE, S_HOLD});
      bus.mwe    <= (nstate != S_STROBE);
      bus.done   <= ((state == S_IDLE) && bus.start &&
                     (bus.length == '0)) ||
                    ((state == S_WREL) && (nstate == S_IDLE));
      if (go) begin
        bus.a_out <= bus.base_addr;
        rem       <= bus.length;
        bank_q    <= bus.bank;
        bus.err   <= 1'b0;
        bus.busy  <= 1'b1;
      end
      if ((state == S_REQ) && (nstate == S_IDLE)) begin
        bus.err  <= 1'b1;
        bus.busy <= 1'b0;
      end
      if ((state == S_REQ) && (nstate == S_ADDR))
        bus.ma14 <= bank_q;
      if ((state == S_ADDR) && (nstate == S_SETUP))
        bus.d_out <= bus.s_data;
      if ((state == S_HOLD) && (nstate != S_HOLD)) begin
        rem <= rem - 1'b1;
        if (nstate == S_ADDR)
          bus.a_out <= bus.a_out + 1'b1;
      end
      if ((state == S_WREL) && (nstate == S_IDLE))
        bus.busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z80_cache_loader.sv
// tb_z80_cache_loader: randomized loads against a write-list model,
// plus reset, wrap, timeout, abort, zero-length and busy-start cases.
module tb_z80_cache_loader;
  import z80db_pkg::*;

  localparam int SETUP_CYC   = 1;
  localparam int WE_CYC      = 2;
  localparam int HOLD_CYC    = 1;
  localparam int ACK_TIMEOUT = 1023;
  localparam int PER         = 10;
  localparam int BYTE_PER    = 1 + SETUP_CYC + WE_CYC + HOLD_CYC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #(PER / 2) clk = ~clk;

  z80_cache_loader_if bus();

  z80_cache_loader #(
    .SETUP_CYC   (SETUP_CYC),
    .WE_CYC      (WE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl_vec();
    return {bus.busrq, bus.bus_oe, bus.mce, bus.mwe, bus.moe,
            bus.s_ready, bus.busy, bus.done, bus.err};
  endfunction

  // Z80 side: grant BUSAK some clocks after BUSRQ, drop it after release
  bit  ack_en  = 1'b1;
  int  ack_dly = 3;
  time rise_t  = 0;
  initial begin
    int k = 0;
    bus.busak = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.busrq && bus.busak && ack_en) begin
        if (k >= ack_dly) begin bus.busak = 1'b0; k = 0; end
        else k++;
      end else if (bus.busrq && !bus.busak) begin
        if (k >= 1) begin
          bus.busak = 1'b1; rise_t = $time; k = 0;
        end else k++;
      end else k = 0;
    end
  end

  // host stream: entries are (gap << 8) | byte
  int tx_q[$];
  initial begin
    bit fire;
    bit flush;
    int gl = -1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(negedge clk);
      fire  = bus.s_valid && bus.s_ready;
      flush = bus.done || reset;
      @(posedge clk);
      #1;
      if (flush) tx_q.delete();
      else if (fire && tx_q.size() > 0) begin
        void'(tx_q.pop_front());
        gl = -1;
      end
      if (tx_q.size() == 0) begin
        bus.s_valid = 1'b0;
        gl = -1;
      end else begin
        if (gl < 0) gl = tx_q[0] >> 8;
        if (gl > 0) begin
          bus.s_valid = 1'b0;
          gl--;
        end else begin
          bus.s_valid = 1'b1;
          bus.s_data  = 8'(tx_q[0]);
        end
      end
    end
  end

  // SRAM pin monitor: one record per CE-low window
  // {oe_ok, stable, hold[3:0], we[3:0], setup[3:0], ma14, addr, data}
  logic [36:0] wr_q[$];
  time         fall_q[$];
  int          done_cnt = 0;
  int          rq_low   = 0;
  time         done_t   = 0;
  initial begin
    int su = 0, we = 0, ho = 0;
    bit in_cyc = 0, stb = 1, oek = 1;
    logic [22:0] held = '0;
    forever begin
      @(negedge clk);
      if (reset) in_cyc = 0;
      else begin
        if (bus.done) begin done_cnt++; done_t = $time; end
        if (!bus.busrq) rq_low++;
        if (!bus.mce) begin
          if (!in_cyc) begin
            in_cyc = 1; held = {bus.ma14, bus.a_out, bus.d_out};
            su = 0; we = 0; ho = 0; stb = 1; oek = 1;
          end
          if ({bus.ma14, bus.a_out, bus.d_out} != held) stb = 0;
          if (!bus.bus_oe || !bus.moe) oek = 0;
          if (!bus.mwe) begin
            if (we == 0) fall_q.push_back($time);
            if (ho != 0) stb = 0;
            we++;
          end else if (we == 0) su++;
          else ho++;
        end else if (in_cyc) begin
          in_cyc = 0;
          wr_q.push_back({oek, stb, 4'(ho), 4'(we), 4'(su), held});
        end
      end
    end
  end

  int exp_d[$];

  task automatic push_byte(int d, int g);
    tx_q.push_back((g << 8) | (d & 255));
    exp_d.push_back(d & 255);
  endtask

  task automatic start_load(int base, int len, logic bk);
    bus.base_addr = 14'(base);
    bus.length    = 15'(len);
    bus.bank      = bk;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(string tag, int d0);
    int k = 0;
    while (done_cnt == d0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask

  // model: byte i lands at (base + i) mod 16K with the chosen bank
  task automatic check_writes(string tag, int base, int n, logic bk,
                              int w0);
    logic [36:0] e;
    chk({tag, "_cnt"}, wr_q.size() - w0, n);
    for (int i = 0; i < n && w0 + i < wr_q.size(); i++) begin
      e = wr_q[w0 + i];
      chk({tag, "_wr"}, e[22:0],
          {bk, 14'((base + i) % 16384), 8'(exp_d[i])});
      chk({tag, "_tim"}, e[36:23],
          {1'b1, 1'b1, 4'(HOLD_CYC), 4'(WE_CYC), 4'(SETUP_CYC)});
    end
  endtask

  initial begin
    #(PER * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0, w0, f0, r0, k;
    bus.start = 1'b0; bus.abort = 1'b0; bus.bank = 1'b0;
    bus.base_addr = '0; bus.length = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ctl", ctl_vec(), 9'b101110000);
    end
    chk("rst_bus", {bus.ma14, bus.a_out, bus.d_out}, 0);

    exp_d.delete(); w0 = wr_q.size(); f0 = fall_q.size();
    d0 = done_cnt; ack_dly = 3;
    push_byte(8'hAA, 0); push_byte(8'h55, 0);
    push_byte(8'h01, 0); push_byte(8'hFF, 0);
    start_load(0, 4, 1'b1);
    wait_done("basic", d0);
    check_writes("basic", 0, 4, 1'b1, w0);
    for (int i = 1; i < 4; i++)
      if (f0 + i < fall_q.size())
        chk("period", int'((fall_q[f0 + i] - fall_q[f0 + i - 1]) / PER),
            BYTE_PER);
    chk("done_lat", int'((done_t - rise_t) / PER), 3);
    chk("basic_end", {bus.busy, bus.busrq, bus.bus_oe, bus.mce}, 4'b0101);

    exp_d.delete(); w0 = wr_q.size(); d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_byte($urandom_range(0, 255), 1);
    start_load(14'h3FFE, 3, 1'b0);
    wait_done("wrap", d0);
    check_writes("wrap", 14'h3FFE, 3, 1'b0, w0);

    ack_en = 1'b0; d0 = done_cnt;
    start_load(14'h0100, 2, 1'b0);
    k = 0;
    while (bus.busrq == 1'b0 && k < 3000) begin
      k++;
      @(negedge clk);
    end
    chk("to_len", k, ACK_TIMEOUT + 1);
    chk("to_flags", {bus.err, bus.busy, bus.bus_oe}, 3'b100);
    repeat (5) @(negedge clk);
    chk("to_nodone", done_cnt - d0, 0);
    ack_en = 1'b1;
    exp_d.delete(); w0 = wr_q.size(); d0 = done_cnt;
    push_byte(8'h3C, 0);
    start_load(14'h1234, 1, 1'b1);
    chk("to_clr", {bus.err, bus.busy}, 2'b01);
    wait_done("to_rec", d0);
    check_writes("to_rec", 14'h1234, 1, 1'b1, w0);

    exp_d.delete(); w0 = wr_q.size(); f0 = fall_q.size();
    d0 = done_cnt; ack_dly = 3;
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 10);
    push_byte(8'h44, 0); push_byte(8'h55, 0);
    start_load(14'h0200, 5, 1'b1);
    k = 0;
    while (fall_q.size() < f0 + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    bus.abort = 1'b1;
    wait_done("abort", d0);
    bus.abort = 1'b0;
    check_writes("abort", 14'h0200, 2, 1'b1, w0);
    chk("abort_rq", {bus.busrq, bus.busy}, 2'b10);

    d0 = done_cnt; r0 = rq_low;
    start_load(14'h0123, 0, 1'b1);
    chk("len0_done", {bus.done, bus.busy, bus.busrq}, 3'b101);
    repeat (3) @(negedge clk);
    chk("len0_norq", rq_low - r0, 0);
    chk("len0_pulse", done_cnt - d0, 1);

    exp_d.delete(); w0 = wr_q.size(); d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_byte($urandom_range(0, 255), 0);
    start_load(100, 3, 1'b0);
    repeat (4) @(negedge clk);
    start_load(200, 9, 1'b1);
    wait_done("busy_st", d0);
    check_writes("busy_st", 100, 3, 1'b0, w0);

    exp_d.delete(); w0 = wr_q.size(); f0 = fall_q.size();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_byte($urandom_range(0, 255), 0);
    start_load(50, 3, 1'b1);
    k = 0;
    while (fall_q.size() < f0 + 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", ctl_vec(), 9'b101110000);
    chk("mid_rst_bus", {bus.ma14, bus.a_out, bus.d_out}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_nowr", wr_q.size() - w0, 0);
    chk("mid_rst_nodone", done_cnt - d0, 0);

    for (int t = 0; t < 16; t++) begin
      int   base, len, gm;
      logic bk;
      base = ($urandom_range(0, 2) == 0) ? 16384 - $urandom_range(1, 5)
                                         : $urandom_range(0, 16383);
      len  = (t == 7) ? 40 : $urandom_range(1, 9);
      bk   = 1'($urandom_range(0, 1));
      gm   = $urandom_range(0, 3);
      ack_dly = $urandom_range(0, 6);
      exp_d.delete(); w0 = wr_q.size(); d0 = done_cnt;
      for (int i = 0; i < len; i++)
        push_byte($urandom_range(0, 255), $urandom_range(0, gm));
      start_load(base, len, bk);
      wait_done("rnd", d0);
      check_writes("rnd", base, len, bk, w0);
      chk("rnd_end", {bus.busy, bus.err, bus.busrq, bus.bus_oe}, 4'b0010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
